// File: rtl/discount_factor_stage.sv
// rtl/discount_factor_stage.sv - range-reducing driver and squaring post-processor for the e^(-x) core
module discount_factor_stage #(
    parameter int WIDTH     = 32,
    parameter int MAX_SHIFT = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] k,
    output logic             exp_start,
    output logic [WIDTH-1:0] exp_x,
    input  logic [WIDTH-1:0] exp_y,
    input  logic             exp_done,
    output logic [WIDTH-1:0] df,
    output logic [WIDTH-1:0] disc_k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int NW = $clog2(MAX_SHIFT + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [WIDTH-1:0] X_HALF = WIDTH'(32'h8000);
    localparam logic signed [WIDTH-1:0] X_MAX  = X_HALF <<< MAX_SHIFT;
    localparam logic        [WIDTH-1:0] ONE    = WIDTH'(32'h10000);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_REDUCE, S_LAUNCH, S_WAIT, S_SQUARE, S_SCALE, S_DONE
    } state_t;

    // Signed Q16.16 multiply: full-width product, keep the middle word (truncating).
    function automatic logic [WIDTH-1:0] qmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        return p[WIDTH+15:16];
    endfunction

    state_t                  state_q, state_d;
    logic                    prev_start_q;
    logic [WIDTH-1:0]        r_q, r_d, t_q, t_d, k_q, k_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic [NW-1:0]           n_q, n_d, n_red;
    logic [WIDTH-1:0]        acc_q, acc_d, sq;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        exp_x_q, exp_x_d, df_q, df_d, disc_k_q, disc_k_d;
    logic                    exp_start_q, exp_start_d, busy_q, busy_d;
    logic                    done_q, done_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            prev_start_q <= 1'b0;
            r_q          <= '0;
            t_q          <= '0;
            k_q          <= '0;
            x_q          <= '0;
            n_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            exp_x_q      <= '0;
            df_q         <= '0;
            disc_k_q     <= '0;
            exp_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_start_q <= start;
            r_q          <= r_d;
            t_q          <= t_d;
            k_q          <= k_d;
            x_q          <= x_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            exp_x_q      <= exp_x_d;
            df_q         <= df_d;
            disc_k_q     <= disc_k_d;
            exp_start_q  <= exp_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        t_d         = t_q;
        k_d         = k_q;
        x_d         = x_q;
        n_d         = n_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        exp_x_d     = exp_x_q;
        df_d        = df_q;
        disc_k_d    = disc_k_q;
        exp_start_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        sq          = qmul(acc_q, acc_q);

        // Scan from the top so the smallest qualifying shift wins.
        n_red = NW'(MAX_SHIFT);
        for (int i = MAX_SHIFT; i >= 0; i--) begin
            if ((x_q >>> i) <= X_HALF) n_red = NW'(i);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !prev_start_q) begin
                    r_d     = r;
                    t_d     = t;
                    k_d     = k;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                x_d     = qmul(r_q, t_q);
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                if (x_q[WIDTH-1]) begin
                    df_d    = ONE;
                    err_d   = 1'b1;
                    state_d = S_SCALE;
                end else if (x_q > X_MAX) begin
                    df_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_SCALE;
                end else begin
                    exp_x_d = WIDTH'(x_q >>> n_red);
                    n_d     = n_red;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                exp_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (exp_done) begin
                    acc_d = exp_y;
                    if (n_q != '0) begin
                        state_d = S_SQUARE;
                    end else begin
                        df_d    = exp_y;
                        state_d = S_SCALE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    df_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_SCALE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SQUARE: begin
                acc_d = sq;
                n_d   = n_q - NW'(1);
                if (n_q == NW'(1)) begin
                    df_d    = sq;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                disc_k_d = qmul(k_q, df_q);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign exp_start = exp_start_q;
    assign exp_x     = exp_x_q;
    assign df        = df_q;
    assign disc_k    = disc_k_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_discount_factor_stage.sv
// tb/tb_discount_factor_stage.sv - randomized self-checking bench for discount_factor_stage
module tb_discount_factor_stage;

    localparam int TIMEOUT   = 64;
    localparam int MAX_SHIFT = 5;

    logic        clk = 1'b0;
    logic        reset, start, exp_done, exp_start, busy, done, err;
    logic [31:0] r, t, k, exp_y, exp_x, df, disc_k;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          core_en    = 1'b1;
    bit          core_force = 1'b0;
    logic [31:0] core_y_forced = 32'h0;
    int          core_lat   = 11;
    int          launch_cnt = 0;
    logic [31:0] core_xs;

    discount_factor_stage #(.WIDTH(32), .MAX_SHIFT(MAX_SHIFT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .r(r), .t(t), .k(k),
        .exp_start(exp_start), .exp_x(exp_x), .exp_y(exp_y), .exp_done(exp_done),
        .df(df), .disc_k(disc_k), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        real v;
        if (core_force) return core_y_forced;
        v = $exp(-real'($signed(x)) / 65536.0) * 65536.0;
        return 32'(int'(v));
    endfunction

    always @(posedge clk) if (exp_start === 1'b1) launch_cnt <= launch_cnt + 1;

    // Exponential core stand-in: answers core_lat cycles after the launch edge, done held two cycles.
    initial begin
        exp_done = 1'b0;
        exp_y    = 32'h0;
        forever begin
            @(negedge clk);
            if (exp_start === 1'b1 && core_en) begin
                core_xs = exp_x;
                repeat (core_lat - 1) @(posedge clk);
                #1;
                exp_y    = core_fn(core_xs);
                exp_done = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                exp_done = 1'b0;
            end
        end
    end

    task automatic model(input logic [31:0] rr, input logic [31:0] tt, input logic [31:0] kk, input int lat_core,
                         output logic [31:0] m_df, output logic [31:0] m_dk, output logic [31:0] m_ex,
                         output logic m_err, output int m_lat, output int m_launch);
        longint x, acc, p;
        int     n;
        x    = (longint'($signed(rr)) * longint'($signed(tt))) >>> 16;
        n    = 0;
        m_ex = 32'h0;
        if (x < 0) begin
            m_df = 32'h10000; m_err = 1'b1; m_lat = 4; m_launch = 0;
        end else if (x > (longint'(32768) << MAX_SHIFT)) begin
            m_df = 32'h0; m_err = 1'b1; m_lat = 4; m_launch = 0;
        end else begin
            while ((x >>> n) > 32768) n++;
            m_ex = 32'(x >>> n);
            acc  = longint'(core_fn(m_ex));
            repeat (n) acc = (acc * acc) >>> 16;
            m_df = 32'(acc); m_err = 1'b0; m_lat = 5 + lat_core + n; m_launch = 1;
        end
        p    = longint'($signed(kk)) * longint'($signed(m_df));
        m_dk = 32'(p >>> 16);
    endtask

    task automatic run_req(input logic [31:0] rr, input logic [31:0] tt, input logic [31:0] kk, input bit hold,
                           output int lat, output logic [31:0] o_df, output logic [31:0] o_dk,
                           output logic [31:0] o_ex, output logic o_err, output int o_launch,
                           output logic o_busy0, output logic o_busy_done);
        int l0;
        @(negedge clk);
        r = rr; t = tt; k = kk; start = 1'b1;
        l0 = launch_cnt;
        @(posedge clk);
        #1;
        o_busy0 = busy;
        if (!hold) start = 1'b0;
        r = $urandom; t = $urandom; k = $urandom;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        o_df = df; o_dk = disc_k; o_ex = exp_x; o_err = err; o_busy_done = busy;
        @(negedge clk);
        o_launch = launch_cnt - l0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; r = 32'h0; t = 32'h0; k = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({exp_start, exp_x, df, disc_k, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got df=%h disc_k=%h exp_x=%h flags=%b want all zero", df, disc_k, exp_x,
                     {exp_start, busy, done, err});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_req(input string name, input logic [31:0] rr, input logic [31:0] tt, input logic [31:0] kk);
        logic [31:0] m_df, m_dk, m_ex, o_df, o_dk, o_ex;
        logic        m_err, o_err, b0, bd;
        int          m_lat, m_l, lat, o_l;
        model(rr, tt, kk, core_lat, m_df, m_dk, m_ex, m_err, m_lat, m_l);
        run_req(rr, tt, kk, 1'b0, lat, o_df, o_dk, o_ex, o_err, o_l, b0, bd);
        n_checks++; if (lat !== m_lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, m_lat); end
        n_checks++; if (o_df !== m_df) begin n_fail++; $display("FAIL %s_df: got %h want %h", name, o_df, m_df); end
        n_checks++; if (o_dk !== m_dk) begin n_fail++; $display("FAIL %s_disc_k: got %h want %h", name, o_dk, m_dk); end
        n_checks++; if (o_err !== m_err) begin n_fail++; $display("FAIL %s_err: got %b want %b", name, o_err, m_err); end
        n_checks++; if (o_l !== m_l) begin n_fail++; $display("FAIL %s_launches: got %0d want %0d", name, o_l, m_l); end
        if (m_l == 1) begin
            n_checks++; if (o_ex !== m_ex) begin n_fail++; $display("FAIL %s_exp_x: got %h want %h", name, o_ex, m_ex); end
        end
        n_checks++;
        if (b0 !== 1'b1 || bd !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy: got start=%b done=%b want 1 0", name, b0, bd);
        end
    endtask

    task automatic test_small_x();
        core_lat = 11; core_force = 1'b0;
        check_req("small_x", 32'h0CCD, 32'h10000, 32'h640000);
    endtask

    task automatic test_range_reduction();
        core_lat = 11; core_force = 1'b1; core_y_forced = 32'h9B45;
        check_req("range_red", 32'h8000, 32'h40000, 32'h640000);
        core_force = 1'b0;
    endtask

    task automatic test_error_paths();
        check_req("negative_x", 32'hFFFF_F333, 32'h10000, 32'h640000);
        check_req("out_of_range", 32'h140000, 32'h10000, 32'h640000);
    endtask

    task automatic test_boundaries();
        check_req("x_max", 32'h100000, 32'h10000, 32'h10000);
        check_req("x_over_max", 32'h100001, 32'h10000, 32'h10000);
        check_req("x_half", 32'h8000, 32'h10000, 32'h320000);
        check_req("x_half_plus", 32'h8001, 32'h10000, 32'h320000);
    endtask

    task automatic test_timeout();
        logic [31:0] o_df, o_dk, o_ex;
        logic        o_err, b0, bd;
        int          lat, o_l, bad;
        core_en = 1'b0;
        run_req(32'h0CCD, 32'h10000, 32'h640000, 1'b1, lat, o_df, o_dk, o_ex, o_err, o_l, b0, bd);
        n_checks++; if (lat !== 5 + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, 5 + TIMEOUT); end
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", o_err); end
        n_checks++; if ({o_df, o_dk} !== 64'h0) begin n_fail++; $display("FAIL timeout_df: got %h/%h want 0/0", o_df, o_dk); end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL held_start_reaccepted: got %0d busy cycles want 0", bad); end
        start = 1'b0;
        core_en = 1'b1;
        repeat (2) @(posedge clk);
        check_req("after_timeout", 32'h1000, 32'h20000, 32'h100000);
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        core_lat = 20;
        @(negedge clk);
        r = 32'h0CCD; t = 32'h10000; k = 32'h640000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({exp_start, exp_x, df, disc_k, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL mid_wait_reset: got df=%h exp_x=%h flags=%b want all zero", df, exp_x, {exp_start, busy, done, err});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL late_exp_done: got %0d active cycles want 0", seen); end
        core_lat = 11;
        check_req("after_reset", 32'h0CCD, 32'h10000, 32'h640000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            core_lat = $urandom_range(1, 20);
            check_req("random", 32'($urandom_range(0, 32'h30000)) - 32'h4000, 32'($urandom_range(0, 32'h80000)),
                      32'($urandom_range(0, 32'h1000000)));
        end
    endtask

    initial begin
        test_reset();
        test_small_x();
        test_range_reduction();
        test_error_paths();
        test_boundaries();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
